// File: rtl/row_packer.sv
// rtl/row_packer.sv - packs a 1-bit-per-pixel beat stream into full image rows for the frame buffer
// Rows are assembled separately from row_data so the next row can start while a write is strobed.
module row_packer #(
  parameter int ROW_W    = 640,
  parameter int IN_W     = 8,
  parameter int NUM_ROWS = 480,
  parameter int BEATS    = ROW_W / IN_W,
  parameter int BEAT_CW  = 7,
  parameter int ROW_CW   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic              ram_full,
  output logic [ROW_W-1:0]  row_data,
  output logic              row_wr_en,
  output logic [ROW_CW-1:0] row_count,
  output logic              frame_done,
  output logic              sof_err
);

  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

  state_t             state;
  logic [BEAT_CW-1:0] beat_cnt;
  logic [ROW_W-1:0]   assembly;
  logic               accept;

  assign in_ready = !ram_full && (state != DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      assembly   <= '0;
      row_data   <= '0;
      row_wr_en  <= 1'b0;
      row_count  <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      row_wr_en <= 1'b0;
      sof_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_sof) begin
            assembly[IN_W-1:0] <= in_data;
            beat_cnt           <= BEAT_CW'(1);
            state              <= PACK;
          end
        end
        PACK: begin
          if (accept) begin
            if (in_sof) begin
              // Resync: a write strobed this cycle belongs to the new count.
              assembly[IN_W-1:0] <= in_data;
              beat_cnt           <= BEAT_CW'(1);
              row_count          <= row_wr_en ? ROW_CW'(1) : '0;
              sof_err            <= (beat_cnt != '0) || (row_count != '0);
            end else begin
              assembly[beat_cnt*IN_W +: IN_W] <= in_data;
              if (beat_cnt == BEAT_CW'(BEATS-1)) begin
                beat_cnt  <= '0;
                row_data  <= {in_data, assembly[ROW_W-IN_W-1:0]};
                row_wr_en <= 1'b1;
                row_count <= row_count + ROW_CW'(1);
                if (row_count == ROW_CW'(NUM_ROWS-1)) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                end
              end else begin
                beat_cnt <= beat_cnt + BEAT_CW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_row_packer.sv
// tb/tb_row_packer.sv - directed bench for row_packer with a row scoreboard
// A second, short-frame instance carries the random-gap frame to keep run time small.
module tb_row_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic         ram_full = 1'b0;
  logic         sel = 1'b0;

  logic         in_valid_a, in_ready_a, wr_a, frame_done_a, sof_err_a;
  logic [639:0] row_data_a;
  logic [8:0]   row_count_a;
  logic         in_valid_b, in_ready_b, wr_b, frame_done_b, sof_err_b;
  logic [639:0] row_data_b;
  logic [2:0]   row_count_b;

  assign in_valid_a = in_valid && !sel;
  assign in_valid_b = in_valid && sel;

  row_packer dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a), .in_sof(in_sof),
    .in_ready(in_ready_a), .ram_full(ram_full), .row_data(row_data_a), .row_wr_en(wr_a),
    .row_count(row_count_a), .frame_done(frame_done_a), .sof_err(sof_err_a)
  );

  row_packer #(.NUM_ROWS(6), .ROW_CW(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b), .in_sof(in_sof),
    .in_ready(in_ready_b), .ram_full(ram_full), .row_data(row_data_b), .row_wr_en(wr_b),
    .row_count(row_count_b), .frame_done(frame_done_b), .sof_err(sof_err_b)
  );

  logic         rdy_s, wr_s;
  logic [639:0] data_s;
  logic [8:0]   cnt_s;
  assign rdy_s  = sel ? in_ready_b : in_ready_a;
  assign wr_s   = sel ? wr_b : wr_a;
  assign data_s = sel ? row_data_b : row_data_a;
  assign cnt_s  = sel ? {6'd0, row_count_b} : row_count_a;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: rows expected from the accepted beat stream
  logic [639:0] exp_q[$];
  logic [639:0] m_row;
  int           m_cnt = 0;
  bit           m_active = 0;
  int           seed = 0;

  int  n_wr = 0;
  int  prev_wr = -1;
  bit  space_on = 0;

  always @(negedge clk) begin
    if (wr_s) begin
      if (exp_q.size() == 0) check_eq("spurious_wr", wr_s, 1'b0);
      else check_eq("row_data", data_s, exp_q.pop_front());
      if (space_on) begin
        check_eq("row_count_at_wr", cnt_s, n_wr + 1);
        if (prev_wr >= 0) check_eq("wr_spacing", cyc - prev_wr, 80);
      end
      prev_wr = cyc;
      n_wr++;
    end
  end

  function automatic logic [7:0] pix(int r, int b);
    return 8'((seed * 7) ^ (r * 37 + b * 11 + ((r * b) >> 2)));
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic s);
    if (s) begin
      m_active = 1;
      m_cnt    = 0;
    end
    if (m_active) begin
      m_row[m_cnt*8 +: 8] = d;
      m_cnt++;
      if (m_cnt == 80) begin
        exp_q.push_back(m_row);
        m_cnt = 0;
      end
    end
  endtask

  logic snap_sof_err;
  logic [8:0] snap_cnt;
  bit   acc;
  int   tries;
  int   full_left = 0;
  bit   rand_valid = 0;

  task automatic beat(input logic v, input logic [7:0] d, input logic s);
    @(negedge clk);
    snap_sof_err = sel ? sof_err_b : sof_err_a;
    snap_cnt     = cnt_s;
    ram_full     = (full_left > 0);
    if (full_left > 0) full_left--;
    in_valid = v;
    in_data  = d;
    in_sof   = s;
    #4;
    if (ram_full) check_eq("ready_while_full", rdy_s, 1'b0);
    acc = v && rdy_s;
    if (acc) model_accept(d, s);
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    tries = 0;
    acc   = 0;
    while (!acc && tries < 200) begin
      if (rand_valid && $urandom_range(0, 1) == 0) beat(1'b0, ~d, s);
      else beat(1'b1, d, s);
      tries++;
    end
    if (!acc) check_eq("send_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      ram_full = 1'b0;
    end
  endtask

  int base;
  int seed_a;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", in_ready_a, 1'b1);
    check_eq("rst_wr", wr_a, 1'b0);
    check_eq("rst_count", row_count_a, 9'd0);
    check_eq("rst_done", frame_done_a, 1'b0);
    check_eq("rst_sof_err", sof_err_a, 1'b0);
    check_eq("rst_row_data", row_data_a, 640'd0);
    check_eq("rst_count_b", row_count_b, 3'd0);

    // Frame A: pre-sof garbage, then a full gap-free frame
    seed   = int'($urandom_range(0, 255));
    seed_a = seed;
    for (int i = 0; i < 20; i++) beat(1'b1, 8'(8'hF0 ^ i), 1'b0);
    check_eq("presof_count", snap_cnt, 9'd0);
    space_on = 1;
    for (int r = 0; r < 480; r++)
      for (int b = 0; b < 80; b++)
        send(pix(r, b), (r == 0 && b == 0));
    idle(1);
    #1;
    check_eq("frame_done", frame_done_a, 1'b1);
    check_eq("frame_count", row_count_a, 9'd480);
    check_eq("frame_wr_total", n_wr, 480);
    check_eq("done_ready", in_ready_a, 1'b0);
    beat(1'b1, 8'h55, 1'b0);
    check_eq("done_accept", acc, 1'b0);
    space_on = 0;
    idle(1);

    // Frame B: resync mid-row, ram_full stall, then reset mid-frame
    rst = 1'b1;
    m_active = 0;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    seed = int'($urandom_range(256, 511));
    for (int r = 0; r < 3; r++)
      for (int b = 0; b < 80; b++)
        send(pix(r, b), (r == 0 && b == 0));
    for (int b = 0; b < 40; b++) send(pix(3, b), 1'b0);
    seed = seed + 1;
    send(pix(0, 0), 1'b1);
    check_eq("sof_err_before", snap_sof_err, 1'b0);
    send(pix(0, 1), 1'b0);
    check_eq("sof_err_pulse", snap_sof_err, 1'b1);
    check_eq("resync_count", snap_cnt, 9'd0);
    send(pix(0, 2), 1'b0);
    check_eq("sof_err_single", snap_sof_err, 1'b0);
    base = n_wr;
    for (int b = 3; b < 80; b++) send(pix(0, b), 1'b0);
    check_eq("resync_no_early_wr", n_wr, base);
    idle(1);
    #1;
    check_eq("resync_wr", n_wr, base + 1);
    check_eq("resync_count_after", row_count_a, 9'd1);

    for (int b = 0; b < 50; b++) send(pix(1, b), 1'b0);
    full_left = 10;
    send(pix(1, 50), 1'b0);
    check_eq("stall_tries", tries, 11);
    for (int b = 51; b < 80; b++) send(pix(1, b), 1'b0);
    for (int r = 2; r < 100; r++)
      for (int b = 0; b < 80; b++)
        send(pix(r, b), 1'b0);
    check_eq("pre_rst_count", snap_cnt, 9'd99);
    for (int b = 0; b < 30; b++) send(pix(100, b), 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    m_active = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_count", row_count_a, 9'd0);
    check_eq("midrst_wr", wr_a, 1'b0);
    check_eq("midrst_ready", in_ready_a, 1'b1);
    check_eq("midrst_queue", exp_q.size(), 0);
    base = n_wr;
    for (int i = 0; i < 85; i++) beat(1'b1, 8'(i * 3), 1'b0);
    idle(2);
    #1;
    check_eq("post_rst_drop_wr", n_wr, base);
    check_eq("post_rst_drop_count", row_count_a, 9'd0);

    // Short frame on dut_b with random valid gaps, same data as frame A
    sel        = 1'b1;
    seed       = seed_a;
    rand_valid = 1;
    base       = n_wr;
    for (int r = 0; r < 6; r++)
      for (int b = 0; b < 80; b++)
        send(pix(r, b), (r == 0 && b == 0));
    rand_valid = 0;
    idle(2);
    #1;
    check_eq("rand_wr_total", n_wr - base, 6);
    check_eq("rand_done", frame_done_b, 1'b1);
    check_eq("rand_count", row_count_b, 3'd6);
    check_eq("rand_ready", in_ready_b, 1'b0);
    check_eq("rand_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/row_packer.md
Name: row_packer

Overview:
- Upstream stage of the row frame buffer in the SAD processor.
- Accepts a narrow pixel stream (1 bit per pixel, IN_W pixels per beat) with valid/ready handshake.
- Packs each ROW_W-bit image row and writes it to the frame buffer with a one-cycle write pulse.
- Stops after NUM_ROWS rows, holding off the source whenever the buffer reports full.

Parameters:
ROW_W, 640, bits (pixels) per packed row; must be a multiple of IN_W
IN_W, 8, pixels per input beat
NUM_ROWS, 480, rows per frame
BEATS, ROW_W/IN_W (80), beats per row (derived)
BEAT_CW, 7, width of beat counter; holds BEATS-1
ROW_CW, 9, width of row counter; holds NUM_ROWS

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_data  in  IN_W  pixel beat; bit 0 is the leftmost pixel of the beat
in_valid  in  1  in_data/in_sof valid
in_sof  in  1  marks first beat of a frame (row 0, beat 0)
in_ready  out  1  beat accepted when in_valid && in_ready
ram_full  in  1  frame buffer full flag, combinational from buffer
row_data  out  ROW_W  packed row to buffer data input
row_wr_en  out  1  one-cycle write strobe for row_data
row_count  out  ROW_CW  rows written this frame
frame_done  out  1  NUM_ROWS rows written; level
sof_err  out  1  one-cycle pulse: in_sof seen mid-frame (resync)

Behaviour:
- Reset is synchronous: rst=1 at a clock edge clears state to IDLE, counters to 0, row_data to 0, row_wr_en/frame_done/sof_err to 0, and discards any partial row. This applies in any state.
- States:
  - IDLE (waiting for sof).
  - PACK (assembling rows).
  - DONE (frame complete).
- Handshake: accept = in_valid && in_ready.
  - in_ready = !ram_full && state!=DONE.
  - in_ready is combinational.
- IDLE:
  - Accepted beats with in_sof=0 are dropped.
  - An accepted beat with in_sof=1 is stored as beat 0 of row 0; go to PACK with beat_cnt=1.
- PACK:
  - Each accepted beat k is written to assembly bits [k*IN_W +: IN_W]; beat_cnt increments.
  - On the accepted beat with beat_cnt==BEATS-1:
    - row_data <= the full assembled row, including this beat.
    - row_wr_en=1 on the next cycle, for exactly one cycle.
    - beat_cnt wraps to 0.
  - The assembly register is independent of row_data. The next row's beats may be accepted during the row_wr_en cycle, so a row every BEATS cycles is sustainable.
  - row_data holds its value until the next row completes.
- row_count increments in the same cycle row_wr_en is high.
  - When row_count reaches NUM_ROWS: state -> DONE and frame_done=1 in the same cycle as the increment is visible.
  - DONE holds until rst; in_ready=0.
- Mid-frame sof: accepted beat with in_sof=1 in PACK while beat_cnt!=0 or row_count!=0.
  - Partial row discarded; the beat becomes beat 0 of row 0.
  - beat_cnt=1; row_count reset to 0.
  - sof_err pulses one cycle later.
  - A row_wr_en already scheduled from the previous cycle still fires; row_count then counts it from 0 (becomes 1).
- ram_full high: in_ready drops immediately; no beat is lost.
  - A row completed before ram_full rose still produces its row_wr_en. The buffer gates that write itself.
- Beats with in_valid=0 change nothing; gaps are allowed anywhere.

Test Plan:
- Reset, then a frame of 480x80 beats with in_sof on first beat, random data, in_valid=1 continuously. Required:
  - 480 row_wr_en pulses, spaced 80 cycles apart.
  - Each row_data equals the concatenated beats, beat0 in bits [7:0].
  - frame_done=1 after the 480th pulse; in_ready=0 thereafter.
- 20 beats with in_sof=0 before sof. Required: beats dropped; first row_data built only from post-sof beats; no row_wr_en until 80 post-sof beats.
- in_sof asserted again at row 3 beat 40. Required:
  - sof_err pulse one cycle later.
  - row_count=0.
  - Next row_wr_en after exactly 80 more beats, containing only new beats.
- ram_full forced high for 10 cycles mid-row (beat 50) with in_valid held. Required:
  - in_ready=0 for those 10 cycles.
  - No beat accepted or lost.
  - Row completes correctly after release.
- rst pulsed for one cycle at row 100 beat 30. Required:
  - Next cycle: state IDLE, row_count=0, row_wr_en=0.
  - Subsequent beats dropped until a new in_sof.
- Random in_valid (50% duty) over a full frame. Required: row data identical to the gap-free run; exactly 480 pulses; frame_done asserted.
